// File: rtl/modinv_helper_update_engine.sv
// Operand-buffer update engine for a binary modular-inverse datapath: sweeps the
// operand sources once and routes the selected words into the r/s/u/v buffers.
module modinv_helper_update_engine #(
   parameter int WORD_W     = 32,
   parameter int NUM_WORDS  = 9,
   parameter int ADDR_BITS  = 4,
   parameter int RD_LATENCY = 1,
   parameter int ITER_W     = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   output logic                 rdy,
   output logic                 done,
   input  logic                 u_gt_v,
   input  logic                 v_eq_1,
   input  logic                 u_is_even,
   input  logic                 v_is_even,
   output logic [ADDR_BITS-1:0] in_addr,
   input  logic [WORD_W-1:0]    r_dbl_din,
   input  logic [WORD_W-1:0]    s_dbl_din,
   input  logic [WORD_W-1:0]    r_plus_s_din,
   input  logic [WORD_W-1:0]    u_half_din,
   input  logic [WORD_W-1:0]    v_half_din,
   input  logic [WORD_W-1:0]    u_minus_v_half_din,
   input  logic [WORD_W-1:0]    v_minus_u_half_din,
   output logic [ADDR_BITS-1:0] out_addr,
   output logic                 r_wren,
   output logic                 s_wren,
   output logic                 u_wren,
   output logic                 v_wren,
   output logic [WORD_W-1:0]    r_dout,
   output logic [WORD_W-1:0]    s_dout,
   output logic [WORD_W-1:0]    u_dout,
   output logic [WORD_W-1:0]    v_dout,
   input  logic                 clr_cnt,
   output logic [ITER_W-1:0]    iter_cnt
);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, SKIP} state_t;

   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);
   localparam logic [1:0]           LAST_DRN  = 2'(RD_LATENCY - 1);

   state_t                 r_state;
   logic                   r_done;
   logic [ADDR_BITS-1:0]   r_in_addr;
   logic [ADDR_BITS-1:0]   r_out_addr;
   logic [RD_LATENCY-1:0]  r_vld;
   logic [1:0]             r_drn;
   logic [ITER_W-1:0]      r_iter;
   logic                   r_u_gt_v;
   logic                   r_v_eq_1;
   logic                   r_u_even;
   logic                   r_v_even;
   logic                   w_wr;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_done     <= 1'b0;
         r_in_addr  <= '0;
         r_out_addr <= '0;
         r_vld      <= '0;
         r_drn      <= '0;
         r_iter     <= '0;
         r_u_gt_v   <= 1'b0;
         r_v_eq_1   <= 1'b0;
         r_u_even   <= 1'b0;
         r_v_even   <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Read-valid pipeline: a word addressed in SWEEP arrives RD_LATENCY cycles later.
         r_vld[0] <= (r_state == SWEEP);
         for (int i = RD_LATENCY - 1; i > 0; i--) r_vld[i] <= r_vld[i-1];

         if (w_wr) r_out_addr <= (r_out_addr == LAST_ADDR) ? '0 : r_out_addr + 1'b1;

         // Skip completions pulse done from SKIP, so only IDLE-state done pulses count.
         if (clr_cnt)                                         r_iter <= '0;
         else if (r_done && r_state == IDLE && r_iter != '1)  r_iter <= r_iter + 1'b1;

         case (r_state)
            IDLE: begin
               if (ena) begin
                  r_u_gt_v <= u_gt_v;
                  r_v_eq_1 <= v_eq_1;
                  r_u_even <= u_is_even;
                  r_v_even <= v_is_even;
                  if (v_eq_1) begin
                     r_state <= SKIP;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= SWEEP;
                     r_in_addr <= '0;
                  end
               end
            end
            SWEEP: begin
               if (r_in_addr == LAST_ADDR) begin
                  r_in_addr <= '0;
                  r_drn     <= '0;
                  r_state   <= DRAIN;
               end else begin
                  r_in_addr <= r_in_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (r_drn == LAST_DRN) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_drn <= r_drn + 1'b1;
               end
            end
            SKIP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_wr = r_vld[RD_LATENCY-1];

   // NOTE: every output of this block gets a default first, so no latch is inferred
   // and unselected write ports drive zeros rather than stale data.
   always_comb begin
      r_wren = 1'b0;
      s_wren = 1'b0;
      u_wren = 1'b0;
      v_wren = 1'b0;
      r_dout = '0;
      s_dout = '0;
      u_dout = '0;
      v_dout = '0;
      if (w_wr) begin
         if (r_u_even) begin
            u_wren = 1'b1;  u_dout = u_half_din;
            s_wren = 1'b1;  s_dout = s_dbl_din;
         end else if (r_v_even) begin
            v_wren = 1'b1;  v_dout = v_half_din;
            r_wren = 1'b1;  r_dout = r_dbl_din;
         end else if (r_u_gt_v) begin
            u_wren = 1'b1;  u_dout = u_minus_v_half_din;
            r_wren = 1'b1;  r_dout = r_plus_s_din;
            s_wren = 1'b1;  s_dout = s_dbl_din;
         end else begin
            v_wren = 1'b1;  v_dout = v_minus_u_half_din;
            r_wren = 1'b1;  r_dout = r_dbl_din;
            s_wren = 1'b1;  s_dout = r_plus_s_din;
         end
      end
   end

   assign rdy      = (r_state == IDLE);
   assign done     = r_done;
   assign in_addr  = r_in_addr;
   assign out_addr = r_out_addr;
   assign iter_cnt = r_iter;

endmodule
